// File: rtl/fft_frame_sequencer.sv
// ---------------------------------------------------------------------------
// fft_frame_sequencer
// Frame-level scheduler for the 64-point in-place FFT core. One frame is 256
// advance steps of the 8-bit step counter:
//   cnt   0.. 63  LOAD     input handshake, advances on i_in_valid
//   cnt  64..223  COMPUTE  free-running butterfly stages 0..4
//   cnt 224..255  DRAIN    final stage plus output, advances on i_out_ready
// It also derives the current stage and the twiddle ROM exponent for the
// butterfly from the counter.
//
// Ports
//   i_clk          system clock, rising edge
//   i_nrst         synchronous active-low reset
//   i_start        level, begins a frame from IDLE (and at end of frame)
//   i_in_valid     upstream sample present
//   o_in_ready     sample accepted (LOAD only)
//   i_out_ready    downstream accepts an output sample
//   o_out_valid    output sample present (DRAIN only)
//   o_cnt          frame step counter to the control block / memories
//   o_valid        advance strobe, o_cnt steps on the edge where it is 1
//   o_stage        FFT stage 0..5 (0 outside COMPUTE/DRAIN)
//   o_tw_addr      twiddle ROM index (exponent of W64)
//   o_busy         sequencer not idle
//   o_frame_done   one-cycle pulse after the last drain step
//   o_frame_cnt    completed frames, wraps
//   i_clr_ovf      clear the overflow flag
//   o_ovf          sticky: i_in_valid seen while o_in_ready=0
// ---------------------------------------------------------------------------
module fft_frame_sequencer #(
  parameter bit AUTO_RESTART = 1'b1,
  parameter int FRAME_CNT_W  = 8
) (
  input  logic                   i_clk,
  input  logic                   i_nrst,
  input  logic                   i_start,
  input  logic                   i_in_valid,
  output logic                   o_in_ready,
  input  logic                   i_out_ready,
  output logic                   o_out_valid,
  output logic [7:0]             o_cnt,
  output logic                   o_valid,
  output logic [2:0]             o_stage,
  output logic [4:0]             o_tw_addr,
  output logic                   o_busy,
  output logic                   o_frame_done,
  output logic [FRAME_CNT_W-1:0] o_frame_cnt,
  input  logic                   i_clr_ovf,
  output logic                   o_ovf
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_COMP  = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;

  localparam logic [FRAME_CNT_W-1:0] FRAME_ONE = {{(FRAME_CNT_W-1){1'b0}}, 1'b1};

  logic [1:0]             r_state, w_state_nxt;
  logic [7:0]             r_cnt, w_cnt_nxt;
  logic                   r_frame_done;
  logic [FRAME_CNT_W-1:0] r_frame_cnt;
  logic                   r_ovf;

  logic                   w_adv;
  logic                   w_frame_end;
  logic                   w_in_fft;
  logic [7:0]             w_ofs;
  logic [4:0]             w_tw;

  // Handshake and advance strobe, purely from state and the handshake inputs.
  always_comb begin
    o_in_ready  = (r_state == S_LOAD);
    o_out_valid = (r_state == S_DRAIN);
    o_busy      = (r_state != S_IDLE);
    case (r_state)
      S_LOAD:  w_adv = i_in_valid;
      S_COMP:  w_adv = 1'b1;
      S_DRAIN: w_adv = i_out_ready;
      default: w_adv = 1'b0;
    endcase
  end

  assign w_frame_end = (r_state == S_DRAIN) && w_adv && (r_cnt == 8'd255);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_state_nxt = S_LOAD;
          w_cnt_nxt   = 8'd0;
        end
      end
      S_LOAD: begin
        if (w_adv) begin
          w_cnt_nxt = r_cnt + 8'd1;
          if (r_cnt == 8'd63) w_state_nxt = S_COMP;
        end
      end
      S_COMP: begin
        w_cnt_nxt = r_cnt + 8'd1;
        if (r_cnt == 8'd223) w_state_nxt = S_DRAIN;
      end
      default: begin
        // DRAIN: 255 -> 0 wrap comes from the 8-bit add
        if (w_adv) begin
          w_cnt_nxt = r_cnt + 8'd1;
          if (r_cnt == 8'd255)
            w_state_nxt = (AUTO_RESTART || i_start) ? S_LOAD : S_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_nrst) begin
      r_state      <= S_IDLE;
      r_cnt        <= 8'd0;
      r_frame_done <= 1'b0;
      r_frame_cnt  <= '0;
      r_ovf        <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_frame_done <= w_frame_end;
      if (w_frame_end) r_frame_cnt <= r_frame_cnt + FRAME_ONE;
      // set has priority over a simultaneous clear
      r_ovf        <= (i_in_valid && !o_in_ready) || (r_ovf && !i_clr_ovf);
    end
  end

  // Stage/twiddle: offset into the compute region; 32 steps per stage, the
  // twiddle exponent for butterfly j in stage s is (j << s) mod 32, so the
  // final stage (s=5) always lands on W^0.
  assign w_in_fft  = (r_state == S_COMP) || (r_state == S_DRAIN);
  assign w_ofs     = r_cnt - 8'd64;
  assign w_tw      = w_ofs[4:0] << w_ofs[7:5];

  assign o_stage      = w_in_fft ? w_ofs[7:5] : 3'd0;
  assign o_tw_addr    = w_in_fft ? w_tw : 5'd0;
  assign o_cnt        = r_cnt;
  assign o_valid      = w_adv;
  assign o_frame_done = r_frame_done;
  assign o_frame_cnt  = r_frame_cnt;
  assign o_ovf        = r_ovf;

endmodule

// File: tb/tb_fft_frame_sequencer.sv
module tb_fft_frame_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic nrst, start, in_valid, out_ready, clr_ovf;

  // main DUT: AUTO_RESTART=0
  logic       in_ready, out_valid, valid, busy, frame_done, ovf;
  logic [7:0] cnt, frame_cnt;
  logic [2:0] stage;
  logic [4:0] tw_addr;

  // second DUT: AUTO_RESTART=1, same stimulus
  logic       a_in_ready, a_out_valid, a_valid, a_busy, a_frame_done, a_ovf;
  logic [7:0] a_cnt, a_frame_cnt;
  logic [2:0] a_stage;
  logic [4:0] a_tw_addr;

  fft_frame_sequencer #(.AUTO_RESTART(1'b0), .FRAME_CNT_W(8)) u_dut (
    .i_clk(clk), .i_nrst(nrst), .i_start(start), .i_in_valid(in_valid),
    .o_in_ready(in_ready), .i_out_ready(out_ready), .o_out_valid(out_valid),
    .o_cnt(cnt), .o_valid(valid), .o_stage(stage), .o_tw_addr(tw_addr),
    .o_busy(busy), .o_frame_done(frame_done), .o_frame_cnt(frame_cnt),
    .i_clr_ovf(clr_ovf), .o_ovf(ovf)
  );

  fft_frame_sequencer #(.AUTO_RESTART(1'b1), .FRAME_CNT_W(8)) u_dut_ar (
    .i_clk(clk), .i_nrst(nrst), .i_start(start), .i_in_valid(in_valid),
    .o_in_ready(a_in_ready), .i_out_ready(out_ready), .o_out_valid(a_out_valid),
    .o_cnt(a_cnt), .o_valid(a_valid), .o_stage(a_stage), .o_tw_addr(a_tw_addr),
    .o_busy(a_busy), .o_frame_done(a_frame_done), .o_frame_cnt(a_frame_cnt),
    .i_clr_ovf(clr_ovf), .o_ovf(a_ovf)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int t64    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0d want=%0d", name, act, exp);
    end
  endtask

  // advance at negedges until the main DUT shows the target count
  task automatic wait_cnt(input int target);
    int n = 0;
    while (cnt != 8'(target) && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (n >= 400) begin
      checks++;
      errors++;
      $display("FAIL wait_cnt timeout got=%0d want=%0d", cnt, target);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_cnt"}, cnt, 0);
    chk({tag, "_frame_cnt"}, frame_cnt, 0);
    chk({tag, "_ovf"}, ovf, 0);
    chk({tag, "_frame_done"}, frame_done, 0);
    chk({tag, "_valid"}, valid, 0);
    chk({tag, "_in_ready"}, in_ready, 0);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_stage"}, stage, 0);
    chk({tag, "_tw_addr"}, tw_addr, 0);
  endtask

  typedef struct {
    int   cnt;        // frame position to reach
    logic out_ready;  // input applied there
    int   stage;
    int   tw;
    logic valid;
    logic out_valid;
  } vec_t;

  vec_t vecs[16];

  initial begin
    // cnt, out_ready, stage, tw_addr, valid, out_valid (hand-computed)
    vecs[0]  = '{64,  1'b1, 0, 0,  1'b1, 1'b0};
    vecs[1]  = '{70,  1'b1, 0, 6,  1'b1, 1'b0};
    vecs[2]  = '{95,  1'b1, 0, 31, 1'b1, 1'b0};
    vecs[3]  = '{96,  1'b1, 1, 0,  1'b1, 1'b0};
    vecs[4]  = '{100, 1'b1, 1, 8,  1'b1, 1'b0};
    vecs[5]  = '{127, 1'b1, 1, 30, 1'b1, 1'b0};
    vecs[6]  = '{128, 1'b1, 2, 0,  1'b1, 1'b0};
    vecs[7]  = '{159, 1'b1, 2, 28, 1'b1, 1'b0};
    vecs[8]  = '{160, 1'b1, 3, 0,  1'b1, 1'b0};
    vecs[9]  = '{165, 1'b1, 3, 8,  1'b1, 1'b0};
    vecs[10] = '{191, 1'b1, 3, 24, 1'b1, 1'b0};
    vecs[11] = '{192, 1'b1, 4, 0,  1'b1, 1'b0};
    vecs[12] = '{200, 1'b1, 4, 0,  1'b1, 1'b0};
    vecs[13] = '{223, 1'b1, 4, 16, 1'b1, 1'b0};
    vecs[14] = '{224, 1'b1, 5, 0,  1'b1, 1'b1};
    vecs[15] = '{230, 1'b1, 5, 0,  1'b1, 1'b1};

    nrst = 1'b0; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0; clr_ovf = 1'b0;
    repeat (3) @(negedge clk);
    nrst = 1'b1;
    #1 chk_reset_vals("reset");

    // overflow while idle, then clear alone
    @(negedge clk) in_valid = 1'b1;
    @(negedge clk) in_valid = 1'b0;
    #1 chk("ovf_idle_set", ovf, 1);
    clr_ovf = 1'b1;
    @(negedge clk) clr_ovf = 1'b0;
    #1 chk("ovf_clr", ovf, 0);

    // frame 1: continuous load
    start = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 64; i++) begin
      #1;
      chk($sformatf("load_cnt%0d", i), cnt, i);
      chk("load_in_ready", in_ready, 1);
      chk("load_valid", valid, 1);
      @(negedge clk);
    end
    in_valid = 1'b0;
    t64 = cyc;
    #1 chk("compute_ovf", ovf, 0);
    chk("compute_in_ready", in_ready, 0);

    for (int k = 0; k < 16; k++) begin
      out_ready = vecs[k].out_ready;
      wait_cnt(vecs[k].cnt);
      #1;
      chk($sformatf("v%0d_stage", k), stage, vecs[k].stage);
      chk($sformatf("v%0d_tw", k), tw_addr, vecs[k].tw);
      chk($sformatf("v%0d_valid", k), valid, vecs[k].valid);
      chk($sformatf("v%0d_in_ready", k), in_ready, 0);
      chk($sformatf("v%0d_out_valid", k), out_valid, vecs[k].out_valid);
      chk($sformatf("v%0d_steps", k), cyc - t64, vecs[k].cnt - 64);
    end

    // drain backpressure at cnt=230
    out_ready = 1'b0;
    #1 chk("bp_valid0", valid, 0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      #1;
      chk("bp_cnt", cnt, 230);
      chk("bp_valid", valid, 0);
      chk("bp_out_valid", out_valid, 1);
      chk("bp_stage", stage, 5);
    end
    out_ready = 1'b1;
    repeat (25) @(negedge clk);
    #1 chk("drain_cnt255", cnt, 255);
    chk("ar_cnt255", a_cnt, 255);
    @(negedge clk);
    #1;
    chk("end1_frame_done", frame_done, 1);
    chk("end1_frame_cnt", frame_cnt, 1);
    chk("end1_busy", busy, 0);
    chk("end1_cnt", cnt, 0);
    chk("ar_end1_busy", a_busy, 1);
    chk("ar_end1_in_ready", a_in_ready, 1);
    chk("ar_end1_frame_cnt", a_frame_cnt, 1);
    chk("ar_end1_frame_done", a_frame_done, 1);
    @(negedge clk);
    #1 chk("end1_done_pulse", frame_done, 0);

    // frame 2: gapped load
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #1 chk("f2_busy", busy, 1);
    for (int i = 0; i < 128; i++) begin
      in_valid = (i % 2 == 1);
      #1;
      chk("gap_valid", valid, in_valid);
      chk($sformatf("gap_cnt%0d", i), cnt, i / 2);
      @(negedge clk);
    end
    in_valid = 1'b0;
    #1;
    chk("gap_cnt64", cnt, 64);
    chk("gap_in_ready", in_ready, 0);
    chk("gap_valid64", valid, 1);

    // overflow in COMPUTE: sticky, set beats clear, clear alone
    @(negedge clk) in_valid = 1'b1;
    @(negedge clk) in_valid = 1'b0;
    #1 chk("ovf_comp_set", ovf, 1);
    repeat (3) @(negedge clk);
    #1 chk("ovf_sticky", ovf, 1);
    in_valid = 1'b1; clr_ovf = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; clr_ovf = 1'b0;
    #1 chk("ovf_set_wins", ovf, 1);
    clr_ovf = 1'b1;
    @(negedge clk) clr_ovf = 1'b0;
    #1 chk("ovf_clr2", ovf, 0);

    // end of frame with start=1 -> straight to LOAD
    wait_cnt(255);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #1;
    chk("end2_frame_done", frame_done, 1);
    chk("end2_frame_cnt", frame_cnt, 2);
    chk("end2_busy", busy, 1);
    chk("end2_in_ready", in_ready, 1);
    chk("end2_cnt", cnt, 0);

    // frame 3: reset mid-compute
    in_valid = 1'b1;
    wait_cnt(64);
    in_valid = 1'b0;
    wait_cnt(150);
    #1 chk("pre_rst_stage", stage, 2);
    nrst = 1'b0;
    @(negedge clk);
    #1 chk_reset_vals("midrst");
    nrst = 1'b1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
